// File: rtl/gp_register_pkg.sv
// Shared CPU constants: default datapath width and counter overflow modes.
package gp_register_pkg;
  localparam int DEFAULT_WIDTH = 12;
  localparam int MODE_WRAP     = 0;
  localparam int MODE_SAT      = 1;
endpackage

// File: rtl/gp_register_if.sv
// Strobe/data bundle of the general-purpose register; master drives ops, slave is the register.
interface gp_register_if
  import gp_register_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] Datain;
  logic             LD;
  logic             INR;
  logic             DCR;
  logic             CLR;
  logic             SHL;
  logic             SHR;
  logic             SIN;
  logic             OVF_CLR;
  logic [WIDTH-1:0] Dataout;
  logic             CARRY;
  logic             OVF;
  logic             ZERO;

  modport master (
    output Datain, LD, INR, DCR, CLR, SHL, SHR, SIN, OVF_CLR,
    input  Dataout, CARRY, OVF, ZERO
  );

  modport slave (
    input  Datain, LD, INR, DCR, CLR, SHL, SHR, SIN, OVF_CLR,
    output Dataout, CARRY, OVF, ZERO
  );
endinterface

// File: rtl/gp_incdec.sv
// Next value and carry/borrow for increment or decrement, with wrap or saturate at the rails.
module gp_incdec
  import gp_register_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] val,
  input  logic             dec,
  output logic [WIDTH-1:0] nxt,
  output logic             carry
);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_comb begin
    nxt   = val;
    carry = 1'b0;
    if (!dec) begin
      if (val == '1) begin
        carry = 1'b1;
        nxt   = (SATURATE == MODE_SAT) ? val : '0;
      end else begin
        nxt = val + ONE;
      end
    end else begin
      if (val == '0) begin
        carry = 1'b1;
        nxt   = (SATURATE == MODE_SAT) ? val : '1;
      end else begin
        nxt = val - ONE;
      end
    end
  end
endmodule

// File: rtl/gp_register.sv
// General-purpose register: clear/load/inc/dec/shift by fixed priority, carry and sticky overflow.
module gp_register
  import gp_register_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               SATURATE  = MODE_WRAP,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic         CLK,
  input logic         RST,
  gp_register_if.slave bus
);
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
  logic [WIDTH-1:0] id_nxt;
  logic             id_carry;

  // INR outranks DCR, so the unit only decrements when INR is low.
  gp_incdec #(
    .WIDTH   (WIDTH),
    .SATURATE(SATURATE)
  ) u_incdec (
    .val  (data_q),
    .dec  (~bus.INR),
    .nxt  (id_nxt),
    .carry(id_carry)
  );

  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    ovf_set = 1'b0;
    if (bus.CLR) begin
      data_d  = '0;
      carry_d = 1'b0;
    end else if (bus.LD) begin
      data_d  = bus.Datain;
      carry_d = 1'b0;
    end else if (bus.INR || bus.DCR) begin
      data_d  = id_nxt;
      carry_d = id_carry;
      ovf_set = id_carry;
    end else if (bus.SHL) begin
      data_d  = {data_q[WIDTH-2:0], bus.SIN};
      carry_d = data_q[WIDTH-1];
    end else if (bus.SHR) begin
      data_d  = {bus.SIN, data_q[WIDTH-1:1]};
      carry_d = data_q[0];
    end
    // A set event in the same cycle wins over OVF_CLR.
    ovf_d = ovf_set | (ovf_q & ~bus.OVF_CLR);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_q  <= RESET_VAL;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.Dataout = data_q;
  assign bus.CARRY   = carry_q;
  assign bus.OVF     = ovf_q;
  assign bus.ZERO    = (data_q == '0);
endmodule

// File: tb/tb_gp_register.sv
// Directed bench for gp_register: a wrap-mode and a saturate-mode instance, RESET_VAL 0x0A5.
module tb_gp_register;
  import gp_register_pkg::*;

  localparam logic [7:0] S_LD  = 8'h01;
  localparam logic [7:0] S_INR = 8'h02;
  localparam logic [7:0] S_DCR = 8'h04;
  localparam logic [7:0] S_CLR = 8'h08;
  localparam logic [7:0] S_SHL = 8'h10;
  localparam logic [7:0] S_SHR = 8'h20;
  localparam logic [7:0] S_SIN = 8'h40;
  localparam logic [7:0] S_OC  = 8'h80;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic clk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  gp_register_if #(.WIDTH(12)) w ();
  gp_register_if #(.WIDTH(12)) s ();

  gp_register #(.WIDTH(12), .SATURATE(MODE_WRAP), .RESET_VAL(12'h0A5)) dut_wrap (
    .CLK(CLK), .RST(RST), .bus(w)
  );
  gp_register #(.WIDTH(12), .SATURATE(MODE_SAT), .RESET_VAL(12'h0A5)) dut_sat (
    .CLK(CLK), .RST(RST), .bus(s)
  );

  always begin
    #5;
    if (clk_en) CLK = ~CLK;
  end

  task automatic op_w(input logic [11:0] d, input logic [7:0] st);
    w.Datain = d;
    {w.OVF_CLR, w.SIN, w.SHR, w.SHL, w.CLR, w.DCR, w.INR, w.LD} = st;
    @(posedge CLK);
    #1;
    {w.OVF_CLR, w.SIN, w.SHR, w.SHL, w.CLR, w.DCR, w.INR, w.LD} = 8'h00;
  endtask

  task automatic op_s(input logic [11:0] d, input logic [7:0] st);
    s.Datain = d;
    {s.OVF_CLR, s.SIN, s.SHR, s.SHL, s.CLR, s.DCR, s.INR, s.LD} = st;
    @(posedge CLK);
    #1;
    {s.OVF_CLR, s.SIN, s.SHR, s.SHL, s.CLR, s.DCR, s.INR, s.LD} = 8'h00;
  endtask

  task automatic test_reset;
    #2 RST = 1'b1;
    #1;
    checks++; if (w.Dataout !== 12'h0A5) begin errors++; $display("FAIL rst_data_wrap: got %h exp 0a5", w.Dataout); end
    checks++; if (w.CARRY !== 1'b0) begin errors++; $display("FAIL rst_carry_wrap: got %b exp 0", w.CARRY); end
    checks++; if (w.OVF !== 1'b0) begin errors++; $display("FAIL rst_ovf_wrap: got %b exp 0", w.OVF); end
    checks++; if (w.ZERO !== 1'b0) begin errors++; $display("FAIL rst_zero_wrap: got %b exp 0", w.ZERO); end
    checks++; if (s.Dataout !== 12'h0A5) begin errors++; $display("FAIL rst_data_sat: got %h exp 0a5", s.Dataout); end
    RST = 1'b0;
    #1 clk_en = 1'b1;
  endtask

  task automatic test_wrap;
    op_w(12'hFFF, S_LD);
    checks++; if (w.Dataout !== 12'hFFF || w.CARRY !== 1'b0) begin errors++; $display("FAIL wrap_ld: got %h/%b exp fff/0", w.Dataout, w.CARRY); end
    op_w(12'h000, S_INR);
    checks++; if (w.Dataout !== 12'h000) begin errors++; $display("FAIL wrap_inr_data: got %h exp 000", w.Dataout); end
    checks++; if (w.CARRY !== 1'b1 || w.OVF !== 1'b1 || w.ZERO !== 1'b1) begin errors++; $display("FAIL wrap_inr_flags: got c%b o%b z%b exp c1 o1 z1", w.CARRY, w.OVF, w.ZERO); end
    op_w(12'h000, S_DCR);
    checks++; if (w.Dataout !== 12'hFFF || w.CARRY !== 1'b1) begin errors++; $display("FAIL wrap_dcr: got %h/%b exp fff/1", w.Dataout, w.CARRY); end
    op_w(12'h005, S_LD);
    op_w(12'h000, S_INR);
    checks++; if (w.Dataout !== 12'h006 || w.CARRY !== 1'b0) begin errors++; $display("FAIL plain_inr: got %h/%b exp 006/0", w.Dataout, w.CARRY); end
    op_w(12'h000, S_DCR);
    checks++; if (w.Dataout !== 12'h005 || w.CARRY !== 1'b0) begin errors++; $display("FAIL plain_dcr: got %h/%b exp 005/0", w.Dataout, w.CARRY); end
  endtask

  task automatic test_saturate;
    op_s(12'hFFF, S_LD);
    op_s(12'h000, S_INR);
    op_s(12'h000, S_INR);
    op_s(12'h000, S_INR);
    checks++; if (s.Dataout !== 12'hFFF) begin errors++; $display("FAIL sat_inr_data: got %h exp fff", s.Dataout); end
    checks++; if (s.OVF !== 1'b1 || s.CARRY !== 1'b1) begin errors++; $display("FAIL sat_inr_flags: got o%b c%b exp o1 c1", s.OVF, s.CARRY); end
    op_s(12'h000, S_OC);
    checks++; if (s.OVF !== 1'b0 || s.Dataout !== 12'hFFF) begin errors++; $display("FAIL sat_ovf_clr: got o%b %h exp o0 fff", s.OVF, s.Dataout); end
    op_s(12'h000, S_LD);
    op_s(12'h000, S_DCR);
    checks++; if (s.Dataout !== 12'h000 || s.OVF !== 1'b1 || s.CARRY !== 1'b1) begin errors++; $display("FAIL sat_dcr: got %h o%b c%b exp 000 o1 c1", s.Dataout, s.OVF, s.CARRY); end
  endtask

  task automatic test_priority;
    op_w(12'h000, S_OC);
    checks++; if (w.OVF !== 1'b0) begin errors++; $display("FAIL prio_ovf_clr: got %b exp 0", w.OVF); end
    op_w(12'h123, S_CLR | S_LD | S_INR);
    checks++; if (w.Dataout !== 12'h000 || w.CARRY !== 1'b0) begin errors++; $display("FAIL prio_clr: got %h/%b exp 000/0", w.Dataout, w.CARRY); end
    op_w(12'h123, S_LD | S_INR);
    checks++; if (w.Dataout !== 12'h123) begin errors++; $display("FAIL prio_ld: got %h exp 123", w.Dataout); end
    op_w(12'h000, S_INR | S_DCR);
    checks++; if (w.Dataout !== 12'h124) begin errors++; $display("FAIL prio_inr: got %h exp 124", w.Dataout); end
    op_w(12'h000, S_DCR | S_SHL | S_SHR);
    checks++; if (w.Dataout !== 12'h123) begin errors++; $display("FAIL prio_dcr: got %h exp 123", w.Dataout); end
    op_w(12'hABC, 8'h00);
    checks++; if (w.Dataout !== 12'h123 || w.CARRY !== 1'b0) begin errors++; $display("FAIL hold: got %h/%b exp 123/0", w.Dataout, w.CARRY); end
    op_w(12'hFFF, S_LD);
    op_w(12'h000, S_INR);
    op_w(12'h000, S_CLR);
    checks++; if (w.OVF !== 1'b1 || w.Dataout !== 12'h000) begin errors++; $display("FAIL clr_keeps_ovf: got o%b %h exp o1 000", w.OVF, w.Dataout); end
    op_w(12'h055, S_LD);
    checks++; if (w.OVF !== 1'b1 || w.Dataout !== 12'h055) begin errors++; $display("FAIL ld_keeps_ovf: got o%b %h exp o1 055", w.OVF, w.Dataout); end
  endtask

  task automatic test_shift;
    op_w(12'h801, S_LD);
    op_w(12'h000, S_SHL | S_SIN);
    checks++; if (w.Dataout !== 12'h003 || w.CARRY !== 1'b1) begin errors++; $display("FAIL shl: got %h/%b exp 003/1", w.Dataout, w.CARRY); end
    op_w(12'h000, S_SHR);
    checks++; if (w.Dataout !== 12'h001 || w.CARRY !== 1'b1) begin errors++; $display("FAIL shr: got %h/%b exp 001/1", w.Dataout, w.CARRY); end
    op_w(12'h000, S_SHR | S_SIN);
    checks++; if (w.Dataout !== 12'h800 || w.CARRY !== 1'b1) begin errors++; $display("FAIL shr_sin: got %h/%b exp 800/1", w.Dataout, w.CARRY); end
    op_w(12'h000, S_SHR);
    checks++; if (w.Dataout !== 12'h400 || w.CARRY !== 1'b0) begin errors++; $display("FAIL shr_c0: got %h/%b exp 400/0", w.Dataout, w.CARRY); end
    op_w(12'h000, S_SHL | S_SHR);
    checks++; if (w.Dataout !== 12'h800 || w.CARRY !== 1'b0) begin errors++; $display("FAIL shl_prio: got %h/%b exp 800/0", w.Dataout, w.CARRY); end
  endtask

  task automatic test_ovf_clr_same;
    op_w(12'h000, S_OC);
    op_w(12'hFFF, S_LD);
    checks++; if (w.OVF !== 1'b0) begin errors++; $display("FAIL ovf_pre: got %b exp 0", w.OVF); end
    op_w(12'h000, S_INR | S_OC);
    checks++; if (w.OVF !== 1'b1 || w.Dataout !== 12'h000) begin errors++; $display("FAIL ovf_set_wins: got o%b %h exp o1 000", w.OVF, w.Dataout); end
  endtask

  task automatic test_async_reset;
    op_w(12'h3C3, S_LD);
    #2 RST = 1'b1;
    #1;
    checks++; if (w.Dataout !== 12'h0A5 || w.OVF !== 1'b0 || w.CARRY !== 1'b0) begin errors++; $display("FAIL async_rst: got %h o%b c%b exp 0a5 o0 c0", w.Dataout, w.OVF, w.CARRY); end
    #1 RST = 1'b0;
    op_w(12'h000, S_INR);
    checks++; if (w.Dataout !== 12'h0A6) begin errors++; $display("FAIL post_rst_inr: got %h exp 0a6", w.Dataout); end
  endtask

  initial begin
    w.Datain = '0; s.Datain = '0;
    {w.OVF_CLR, w.SIN, w.SHR, w.SHL, w.CLR, w.DCR, w.INR, w.LD} = 8'h00;
    {s.OVF_CLR, s.SIN, s.SHR, s.SHL, s.CLR, s.DCR, s.INR, s.LD} = 8'h00;
    test_reset();
    test_wrap();
    test_saturate();
    test_priority();
    test_shift();
    test_ovf_clr_same();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
